kd_tree_traversal_pipe: RTL and testbench

Parametrised, pipelined successor to the single KD-tree internal node. It holds a complete binary tree of 2^LEVELS-1 internal nodes in registers. Each accepted patch is routed root-to-leaf, one tree level per pipeline stage, and the block emits the leaf index together with the unchanged patch. It sits between the patch FIFO and the leaf/candidate memory of the ANN search path.

---
 rtl/kd_tree_traversal_pipe_if.sv | 42 ++++
 rtl/kd_tree_traversal_pipe.sv | 152 +++++++++++++++
 tb/tb_kd_tree_traversal_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/kd_tree_traversal_pipe_if.sv
// Patch/leaf stream and node-write bundle for the KD-tree traversal pipe.
// No latency of its own; it is wiring only.
// Backpressure travels on in_ready/out_ready. The master side is the feeder/consumer.
interface kd_tree_traversal_pipe_if #(
  parameter int DATA_WIDTH    = 11,
  parameter int PATCH_SIZE    = 5,
  parameter int LEVELS        = 3,
  parameter int STORAGE_WIDTH = 2*DATA_WIDTH
);
  logic                             wen;
  logic [LEVELS-1:0]                waddr;
  logic [STORAGE_WIDTH-1:0]         wdata;
  logic                             valid_in;
  logic                             in_ready;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_in;
  logic                             valid_out;
  logic                             out_ready;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_out;
  logic [LEVELS-1:0]                leaf_idx;
  logic                             idx_err;
`ifdef KD_MIN_MARGIN_EN
  logic [DATA_WIDTH:0]              min_margin;

  modport master (
    output wen, waddr, wdata, valid_in, patch_in, out_ready,
    input  in_ready, valid_out, patch_out, leaf_idx, idx_err, min_margin
  );
  modport slave (
    input  wen, waddr, wdata, valid_in, patch_in, out_ready,
    output in_ready, valid_out, patch_out, leaf_idx, idx_err, min_margin
  );
`else
  modport master (
    output wen, waddr, wdata, valid_in, patch_in, out_ready,
    input  in_ready, valid_out, patch_out, leaf_idx, idx_err
  );
  modport slave (
    input  wen, waddr, wdata, valid_in, patch_in, out_ready,
    output in_ready, valid_out, patch_out, leaf_idx, idx_err
  );
`endif
endinterface

// File: rtl/kd_tree_traversal_pipe.sv
// Routes each patch root-to-leaf through a register-held KD tree, one level per stage.
// Latency is LEVELS cycles from accept to valid_out. Throughput is one patch per cycle.
// The whole pipe freezes while valid_out && !out_ready, and in_ready follows the advance.
// The optional min_margin output is built when KD_MIN_MARGIN_EN is defined.
module kd_tree_traversal_pipe #(
  parameter int DATA_WIDTH    = 11,
  parameter int PATCH_SIZE    = 5,
  parameter int LEVELS        = 3,
  parameter int STORAGE_WIDTH = 2*DATA_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  kd_tree_traversal_pipe_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = PATCH_SIZE*DW;
  localparam int MW    = DW + 1;
  // One spare slot keeps every LEVELS-bit address in range. The top slot
  // (all ones) is never written, because it lies outside the heap.
  localparam int NSLOT = 1 << LEVELS;

  logic              adv;
  logic [LEVELS-1:0] err_set;

  logic signed [DW-1:0] med_q  [NSLOT];
  logic        [DW-1:0] nidx_q [NSLOT];

  // Per-stage pipeline registers; stage LEVELS-1 drives the outputs.
  logic              st_vld_q   [LEVELS];
  logic [PW-1:0]     st_patch_q [LEVELS];
  logic [LEVELS-1:0] st_path_q  [LEVELS];

  // Stage inputs and the next-stage values computed from them.
  logic              ev_vld   [LEVELS];
  logic [PW-1:0]     ev_patch [LEVELS];
  logic [LEVELS-1:0] ev_path  [LEVELS];
  logic [LEVELS-1:0] nx_path  [LEVELS];

`ifdef KD_MIN_MARGIN_EN
  logic [MW-1:0] st_marg_q [LEVELS];
  logic [MW-1:0] ev_marg   [LEVELS];
  logic [MW-1:0] nx_marg   [LEVELS];
`endif

  assign adv          = !bus.valid_out || bus.out_ready;
  assign bus.in_ready = adv;

  // Node table. Writes ignore the stall, so the firmware can update nodes at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NSLOT; n++) begin
        med_q[n]  <= '0;
        nidx_q[n] <= '0;
      end
    end else if (bus.wen && (bus.waddr != '1)) begin
      med_q[bus.waddr]  <= bus.wdata[2*DW-1:DW];
      nidx_q[bus.waddr] <= bus.wdata[DW-1:0];
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_stage
    logic [LEVELS-1:0]    addr;
    logic signed [DW-1:0] node_med;
    logic        [DW-1:0] node_idx;
    logic signed [DW-1:0] elem;
    logic                 oor;
    logic                 dec;

    if (l == 0) begin : g_src
      assign ev_vld[l]   = bus.valid_in;
      assign ev_patch[l] = bus.patch_in;
      assign ev_path[l]  = '0;
`ifdef KD_MIN_MARGIN_EN
      assign ev_marg[l]  = '1;
`endif
    end else begin : g_src
      assign ev_vld[l]   = st_vld_q[l-1];
      assign ev_patch[l] = st_patch_q[l-1];
      assign ev_path[l]  = st_path_q[l-1];
`ifdef KD_MIN_MARGIN_EN
      assign ev_marg[l]  = st_marg_q[l-1];
`endif
    end

    // Level l starts at heap slot 2^l-1. The path so far holds exactly l bits.
    assign addr     = LEVELS'((1 << l) - 1) + ev_path[l];
    assign node_med = med_q[addr];
    assign node_idx = nidx_q[addr];
    assign oor      = (node_idx >= DW'(PATCH_SIZE));

    // Select the element the node splits on. An out-of-range index selects 0.
    always_comb begin
      elem = '0;
      for (int i = 0; i < PATCH_SIZE; i++) begin
        if (node_idx == DW'(i)) elem = ev_patch[l][i*DW +: DW];
      end
    end

    // A tie goes right. A bad index is forced left.
    assign dec        = !oor && !(elem < node_med);
    assign nx_path[l] = (ev_path[l] << 1) | LEVELS'(dec);
    assign err_set[l] = ev_vld[l] && oor && adv;

`ifdef KD_MIN_MARGIN_EN
    logic signed [MW-1:0] diff;
    logic        [MW-1:0] mag;

    // One extra bit holds the full difference, so |diff| cannot overflow.
    assign diff       = {elem[DW-1], elem} - {node_med[DW-1], node_med};
    assign mag        = oor ? '0 : (diff[MW-1] ? MW'(-diff) : MW'(diff));
    assign nx_marg[l] = (mag < ev_marg[l]) ? mag : ev_marg[l];
`endif
  end

  // Shift all stages together on advance. The data of a bubble is not loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LEVELS; s++) begin
        st_vld_q[s]   <= 1'b0;
        st_patch_q[s] <= '0;
        st_path_q[s]  <= '0;
`ifdef KD_MIN_MARGIN_EN
        st_marg_q[s]  <= '0;
`endif
      end
    end else if (adv) begin
      for (int s = 0; s < LEVELS; s++) begin
        st_vld_q[s] <= ev_vld[s];
        if (ev_vld[s]) begin
          st_patch_q[s] <= ev_patch[s];
          st_path_q[s]  <= nx_path[s];
`ifdef KD_MIN_MARGIN_EN
          st_marg_q[s]  <= nx_marg[s];
`endif
        end
      end
    end
  end

  // Sticky flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bus.idx_err <= 1'b0;
    else if (|err_set) bus.idx_err <= 1'b1;
  end

  assign bus.valid_out  = st_vld_q[LEVELS-1];
  assign bus.patch_out  = st_patch_q[LEVELS-1];
  assign bus.leaf_idx   = st_path_q[LEVELS-1];
`ifdef KD_MIN_MARGIN_EN
  assign bus.min_margin = st_marg_q[LEVELS-1];
`endif
endmodule

// File: tb/tb_kd_tree_traversal_pipe.sv
// Directed bench for kd_tree_traversal_pipe with a two-level tree.
// Every expected leaf, patch and margin is worked out by hand from the node words.
// Inputs are driven and outputs are sampled 1 ns after the rising edge.
module tb_kd_tree_traversal_pipe;
  localparam int DW = 11;
  localparam int PS = 5;
  localparam int LV = 2;
  localparam int PW = PS*DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kd_tree_traversal_pipe_if #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEVELS(LV)) bus ();

  kd_tree_traversal_pipe #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEVELS(LV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4);
    return {DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic wr(input int a, input int med, input int idx);
    bus.wen   = 1'b1;
    bus.waddr = LV'(a);
    bus.wdata = {DW'(med), DW'(idx)};
    step();
    bus.wen   = 1'b0;
  endtask

  // Single patch: no output after one edge, result after exactly two edges.
  task automatic run_one(input logic [PW-1:0] p, input logic [LV-1:0] exp_leaf,
                         input int exp_marg, input string tag);
    bus.valid_in = 1'b1;
    bus.patch_in = p;
    step();
    bus.valid_in = 1'b0;
    check({tag, "_vld_early"}, 64'(bus.valid_out), 64'd0);
    step();
    check({tag, "_vld"},   64'(bus.valid_out), 64'd1);
    check({tag, "_leaf"},  64'(bus.leaf_idx),  64'(exp_leaf));
    check({tag, "_patch"}, 64'(bus.patch_out), 64'(p));
`ifdef KD_MIN_MARGIN_EN
    check({tag, "_marg"},  64'(bus.min_margin), 64'(exp_marg));
`else
    if (exp_marg < 0) $display("note: negative margin expectation %0d", exp_marg);
`endif
    step();
  endtask

  logic [PW-1:0]  pa, pb, pc;
  logic [LV-1:0]  got_leaf  [3];
  logic [PW-1:0]  got_patch [3];
  int             n_out;

  initial begin
    // Reset with the write strobe and valid_in both active.
    bus.wen       = 1'b1;
    bus.waddr     = '0;
    bus.wdata     = {DW'(2), DW'(1)};
    bus.valid_in  = 1'b1;
    bus.patch_in  = mk(5, 1, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_vld",  64'(bus.valid_out), 64'd0);
      check("rst_leaf", 64'(bus.leaf_idx),  64'd0);
      check("rst_err",  64'(bus.idx_err),   64'd0);
    end
    bus.wen      = 1'b0;
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("rst_rdy", 64'(bus.in_ready), 64'd1);
    check("rst_patch", 64'(bus.patch_out), 64'd0);
    step();

    // The tree is still all zero, so the patch goes right at both levels.
    // Margins: |5-0| at the root and |5-0| at node2.
    run_one(mk(5, 1, 0, 0, 0), 2'b11, 5, "t1_nowrite");

    // Basic traversal: the root goes left (1<2) and node1 goes right (0>=0).
    wr(0, 2, 1); wr(1, 0, 4); wr(2, 5, 0);
    run_one(mk(3, 1, 3, 3, 0), 2'b01, 0, "t2");

    // Signed compare at the root {2,4}, streamed back to back.
    wr(0, 2, 4);
    pa = mk(0, 0, 0, 0, -1024);   // left, then node1 -1024<0 left  -> 00
    pb = mk(7, 0, 0, 0, 512);     // right, then node2 7>=5 right   -> 11
    bus.valid_in = 1'b1; bus.patch_in = pa; step();
    bus.patch_in = pb; step();
    bus.valid_in = 1'b0;
    check("t3_a_vld",   64'(bus.valid_out), 64'd1);
    check("t3_a_leaf",  64'(bus.leaf_idx),  64'd0);
    check("t3_a_patch", 64'(bus.patch_out), 64'(pa));
    step();
    check("t3_b_vld",   64'(bus.valid_out), 64'd1);
    check("t3_b_leaf",  64'(bus.leaf_idx),  64'd3);
    check("t3_b_patch", 64'(bus.patch_out), 64'(pb));
    step();
    check("t3_drain",   64'(bus.valid_out), 64'd0);

    // Backpressure: three patches, with a 4-cycle stall once the first is out.
    pc = mk(1, 0, 0, 0, 512);     // right, then node2 1<5 left     -> 10
    bus.valid_in = 1'b1; bus.patch_in = pa; step();
    bus.patch_in = pb; step();
    bus.patch_in  = pc;
    bus.out_ready = 1'b0;
    #1;
    check("t4_rdy_low", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_hold_vld",   64'(bus.valid_out), 64'd1);
      check("t4_hold_leaf",  64'(bus.leaf_idx),  64'd0);
      check("t4_hold_patch", 64'(bus.patch_out), 64'(pa));
      check("t4_hold_rdy",   64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    n_out = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (bus.valid_out) begin
        if (n_out < 3) begin
          got_leaf[n_out]  = bus.leaf_idx;
          got_patch[n_out] = bus.patch_out;
        end
        n_out++;
      end
      step();
      if (cyc == 0) bus.valid_in = 1'b0;
    end
    check("t4_count", 64'(n_out), 64'd3);
    check("t4_leaf0", 64'(got_leaf[0]), 64'd0);
    check("t4_leaf1", 64'(got_leaf[1]), 64'd3);
    check("t4_leaf2", 64'(got_leaf[2]), 64'd2);
    check("t4_patch0", 64'(got_patch[0]), 64'(pa));
    check("t4_patch1", 64'(got_patch[1]), 64'(pb));
    check("t4_patch2", 64'(got_patch[2]), 64'(pc));

    // Out-of-range index: forced left, and the sticky error is set.
    check("t5_err_pre", 64'(bus.idx_err), 64'd0);
    wr(0, 2, 7);
    run_one(mk(0, 0, 0, 0, 3), 2'b01, 0, "t5_oor");
    check("t5_err_set", 64'(bus.idx_err), 64'd1);
    wr(0, 2, 4);
    // Margins: |512-2|=510 at the root and |7-5|=2 at node2.
    run_one(mk(7, 0, 0, 0, 512), 2'b11, 2, "t5_inr");
    check("t5_err_sticky", 64'(bus.idx_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_err_clr", 64'(bus.idx_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // A write in the same cycle as the root evaluation: the old value is used there.
    wr(0, 2, 4); wr(1, 0, 4); wr(2, 5, 0);
    bus.valid_in = 1'b1;
    bus.patch_in = mk(7, 0, 0, 0, 512);
    bus.wen      = 1'b1;
    bus.waddr    = 2'd0;
    bus.wdata    = {DW'(600), DW'(4)};
    step();
    bus.valid_in = 1'b0;
    bus.wen      = 1'b0;
    step();
    check("t6_old_vld",  64'(bus.valid_out), 64'd1);
    check("t6_old_leaf", 64'(bus.leaf_idx),  64'd3);
    step();
    // New root {600,4}: 512<600 left, then node1 512>=0 right.
    // Margins: |512-600|=88 and |512-0|=512.
    run_one(mk(7, 0, 0, 0, 512), 2'b01, 88, "t6_new");

    // Margin pair: node1 {0,4} gives min(1,0)=0; node1 {-3,4} gives min(1,3)=1.
    wr(0, 2, 1); wr(1, 0, 4); wr(2, 5, 0);
    run_one(mk(3, 1, 3, 3, 0), 2'b01, 0, "t7_m0");
    wr(1, -3, 4);
    run_one(mk(3, 1, 3, 3, 0), 2'b01, 1, "t7_m1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got=running expected=done");
    $fatal(1, "watchdog expired");
  end
endmodule
